// File: rtl/uart_rx_pkt_ctrl_if.sv
// Bundles the receiver-side strobes and the packet-stream consumer port of uart_rx_pkt_ctrl.
// Optional statistics outputs appear when UART_PKT_STATS_EN is defined.
interface uart_rx_pkt_ctrl_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          rx_eop;
  logic [7:0]    m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   pkt_count;
  logic          busy;
  logic          drop_pulse;
`ifdef UART_PKT_STATS_EN
  logic [15:0]   drop_count;
  logic [AW:0]   max_fill;
`endif

  // master: the environment (UART receiver plus packet consumer)
  modport master (
    output rx_ready, rx_data, rx_eop, m_ready,
    input  m_data, m_last, m_valid, pkt_count, busy, drop_pulse
`ifdef UART_PKT_STATS_EN
    , input drop_count, max_fill
`endif
  );

  // slave: the packet controller itself
  modport slave (
    input  rx_ready, rx_data, rx_eop, m_ready,
    output m_data, m_last, m_valid, pkt_count, busy, drop_pulse
`ifdef UART_PKT_STATS_EN
    , output drop_count, max_fill
`endif
  );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the UART receiver: commit/rollback byte FIFO exposing only whole packets.
// Define UART_PKT_STATS_EN to add the drop_count / max_fill statistics outputs.
module uart_rx_pkt_ctrl #(
  parameter int DEPTH   = 64,
  parameter int MAX_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_rx_pkt_ctrl_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  state_t        r_state;
  logic [8:0]    r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_wr_cmt;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_pkt_count;
  logic [7:0]    r_stg;
  logic [LW-1:0] r_len;
  logic          r_drop_pulse;

  logic [AW:0]   w_fill;
  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic [8:0]    w_head;
  logic          w_wr_en;
  logic          w_wr_last;
  logic          w_commit;
  logic          w_drop;

  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_fill == (AW+1)'(DEPTH));
  assign w_valid = (r_rd_ptr != r_wr_cmt);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop   = w_valid && bus.m_ready;

  // The staged byte is only written once the next event says whether it ends the packet.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_wr_en   = 1'b0;
    w_wr_last = 1'b0;
    w_commit  = 1'b0;
    w_drop    = 1'b0;
    if (r_state == S_RECV) begin
      if (bus.rx_ready) begin
        if (r_len == LW'(MAX_LEN) || w_full) w_drop  = 1'b1;
        else                                 w_wr_en = 1'b1;
      end else if (bus.rx_eop) begin
        if (w_full) begin
          w_drop = 1'b1;
        end else begin
          w_wr_en   = 1'b1;
          w_wr_last = 1'b1;
          w_commit  = 1'b1;
        end
      end
    end
  end

  // NOTE: storage has no reset; pointers alone define which entries hold data.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {w_wr_last, r_stg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_wr_cmt     <= '0;
      r_rd_ptr     <= '0;
      r_pkt_count  <= '0;
      r_stg        <= '0;
      r_len        <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      r_drop_pulse <= w_drop;

      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

      // A commit and a last-byte pop in the same cycle cancel out.
      if (w_commit && !(w_pop && w_head[8]))      r_pkt_count <= r_pkt_count + 1'b1;
      else if (!w_commit && w_pop && w_head[8])   r_pkt_count <= r_pkt_count - 1'b1;

      if (w_drop)       r_wr_ptr <= r_wr_cmt;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;

      if (w_commit) r_wr_cmt <= r_wr_ptr + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.rx_ready) begin
            r_stg   <= bus.rx_data;
            r_len   <= LW'(1);
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (bus.rx_ready) begin
            if (w_drop) begin
              r_state <= S_DROP;
            end else begin
              r_stg <= bus.rx_data;
              r_len <= r_len + 1'b1;
            end
          end else if (bus.rx_eop) begin
            r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.rx_eop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_data     = w_head[7:0];
  assign bus.m_last     = w_head[8];
  assign bus.m_valid    = w_valid;
  assign bus.pkt_count  = r_pkt_count;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.drop_pulse = r_drop_pulse;

`ifdef UART_PKT_STATS_EN
  logic [15:0] r_drop_count;
  logic [AW:0] r_max_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count <= '0;
      r_max_fill   <= '0;
    end else begin
      if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 1'b1;
      if (w_fill > r_max_fill)                r_max_fill   <= w_fill;
    end
  end

  assign bus.drop_count = r_drop_count;
  assign bus.max_fill   = r_max_fill;
`endif
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Bench for uart_rx_pkt_ctrl: a default instance and a DEPTH=4 instance share one receiver stream,
// each tracked by a queue-based packet model; directed scenarios add their own checks.
module tb_uart_rx_pkt_ctrl;
  localparam int BIG_DEPTH   = 64;
  localparam int BIG_MAXLEN  = 32;
  localparam int SML_DEPTH   = 4;
  localparam int SML_MAXLEN  = 4;
  localparam int M_IDLE = 0, M_RECV = 1, M_DROP = 2;

  logic       clk;
  logic       rst_n;
  logic       rx_ready, rx_eop;
  logic [7:0] rx_data;
  logic       m_ready_big, m_ready_sml;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_pkt_ctrl_if #(.DEPTH(BIG_DEPTH)) big_if ();
  uart_rx_pkt_ctrl_if #(.DEPTH(SML_DEPTH)) sml_if ();

  assign big_if.rx_ready = rx_ready;
  assign big_if.rx_data  = rx_data;
  assign big_if.rx_eop   = rx_eop;
  assign big_if.m_ready  = m_ready_big;
  assign sml_if.rx_ready = rx_ready;
  assign sml_if.rx_data  = rx_data;
  assign sml_if.rx_eop   = rx_eop;
  assign sml_if.m_ready  = m_ready_sml;

  uart_rx_pkt_ctrl #(.DEPTH(BIG_DEPTH), .MAX_LEN(BIG_MAXLEN)) u_big (
    .clk(clk), .rst_n(rst_n), .bus(big_if.slave));
  uart_rx_pkt_ctrl #(.DEPTH(SML_DEPTH), .MAX_LEN(SML_MAXLEN)) u_sml (
    .clk(clk), .rst_n(rst_n), .bus(sml_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT outputs gathered per instance (index 0 = default, 1 = DEPTH 4)
  logic        d_valid [2];
  logic        d_last  [2];
  logic [7:0]  d_data  [2];
  logic [31:0] d_pc    [2];
  logic        d_busy  [2];
  logic        d_drop  [2];
`ifdef UART_PKT_STATS_EN
  logic [31:0] d_dcnt  [2];
  logic [31:0] d_maxf  [2];
`endif

  always_comb begin
    d_valid[0] = big_if.m_valid;   d_valid[1] = sml_if.m_valid;
    d_last[0]  = big_if.m_last;    d_last[1]  = sml_if.m_last;
    d_data[0]  = big_if.m_data;    d_data[1]  = sml_if.m_data;
    d_pc[0]    = 32'(big_if.pkt_count);
    d_pc[1]    = 32'(sml_if.pkt_count);
    d_busy[0]  = big_if.busy;      d_busy[1]  = sml_if.busy;
    d_drop[0]  = big_if.drop_pulse; d_drop[1] = sml_if.drop_pulse;
`ifdef UART_PKT_STATS_EN
    d_dcnt[0]  = 32'(big_if.drop_count);
    d_dcnt[1]  = 32'(sml_if.drop_count);
    d_maxf[0]  = 32'(big_if.max_fill);
    d_maxf[1]  = 32'(sml_if.max_fill);
`endif
  end

  // Reference model: committed bytes as {last,data} queue, current packet as a byte list.
  logic [8:0] mq [2][$];
  logic [7:0] mp [2][$];
  int         ms [2];
  bit         ex_drop [2];
  int         ex_dcnt [2];
  int         ex_maxf [2];

  task automatic model_step(input int k, input bit mrdy);
    int occ, dep, mlen;
    bit full;
    dep  = (k == 0) ? BIG_DEPTH  : SML_DEPTH;
    mlen = (k == 0) ? BIG_MAXLEN : SML_MAXLEN;
    occ  = mq[k].size() + ((ms[k] == M_RECV) ? mp[k].size() - 1 : 0);
    full = (occ == dep);
    if (occ > ex_maxf[k]) ex_maxf[k] = occ;
    ex_drop[k] = 1'b0;
    if (mrdy && mq[k].size() != 0) void'(mq[k].pop_front());
    case (ms[k])
      M_IDLE: if (rx_ready) begin
        mp[k].delete();
        mp[k].push_back(rx_data);
        ms[k] = M_RECV;
      end
      M_RECV: if (rx_ready) begin
        if (mp[k].size() == mlen || full) begin
          ex_drop[k] = 1'b1; mp[k].delete(); ms[k] = M_DROP;
        end else begin
          mp[k].push_back(rx_data);
        end
      end else if (rx_eop) begin
        if (full) begin
          ex_drop[k] = 1'b1;
        end else begin
          for (int i = 0; i < mp[k].size(); i++)
            mq[k].push_back({(i == mp[k].size() - 1), mp[k][i]});
        end
        mp[k].delete();
        ms[k] = M_IDLE;
      end
      default: if (rx_eop) ms[k] = M_IDLE;
    endcase
    if (ex_drop[k] && ex_dcnt[k] < 65535) ex_dcnt[k]++;
  endtask

  function automatic int model_pkts(input int k);
    int c = 0;
    for (int i = 0; i < mq[k].size(); i++) if (mq[k][i][8]) c++;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete(); mp[k].delete();
        ms[k] = M_IDLE; ex_drop[k] = 1'b0; ex_dcnt[k] = 0; ex_maxf[k] = 0;
      end
    end else begin
      model_step(0, m_ready_big);
      model_step(1, m_ready_sml);
    end
  end

  // Scoreboard: every falling edge, both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (d_valid[k] !== (mq[k].size() != 0)) begin
        n_fail++; $display("FAIL mon%0d_valid: got %b want %b", k, d_valid[k], mq[k].size() != 0);
      end
      if (mq[k].size() != 0) begin
        n_tests++;
        if ({d_last[k], d_data[k]} !== mq[k][0]) begin
          n_fail++; $display("FAIL mon%0d_head: got %h want %h", k, {d_last[k], d_data[k]}, mq[k][0]);
        end
      end
      n_tests++;
      if (d_pc[k] !== 32'(model_pkts(k)) || d_busy[k] !== (ms[k] != M_IDLE) || d_drop[k] !== ex_drop[k]) begin
        n_fail++;
        $display("FAIL mon%0d_status: got pc=%0d busy=%b drop=%b want pc=%0d busy=%b drop=%b",
                 k, d_pc[k], d_busy[k], d_drop[k], model_pkts(k), ms[k] != M_IDLE, ex_drop[k]);
      end
`ifdef UART_PKT_STATS_EN
      n_tests++;
      if (d_dcnt[k] !== 32'(ex_dcnt[k]) || d_maxf[k] !== 32'(ex_maxf[k])) begin
        n_fail++;
        $display("FAIL mon%0d_stats: got dcnt=%0d maxf=%0d want dcnt=%0d maxf=%0d",
                 k, d_dcnt[k], d_maxf[k], ex_dcnt[k], ex_maxf[k]);
      end
`endif
    end
  end

  // Stimulus drivers: called at a falling edge, return one cycle later at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1; rx_data = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_eop();
    rx_eop = 1'b1;
    @(negedge clk);
    rx_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    n_tests++;
    if ({big_if.m_valid, big_if.busy, big_if.drop_pulse, big_if.pkt_count} !== '0) begin
      n_fail++; $display("FAIL reset_big: got v=%b b=%b d=%b pc=%0d want all 0",
                         big_if.m_valid, big_if.busy, big_if.drop_pulse, big_if.pkt_count);
    end
    n_tests++;
    if ({sml_if.m_valid, sml_if.busy, sml_if.drop_pulse, sml_if.pkt_count} !== '0) begin
      n_fail++; $display("FAIL reset_sml: got v=%b b=%b d=%b pc=%0d want all 0",
                         sml_if.m_valid, sml_if.busy, sml_if.drop_pulse, sml_if.pkt_count);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp = '{8'h11, 8'h22, 8'h33};
    m_ready_big = 1'b1; m_ready_sml = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_eop();
    n_tests++;
    if (big_if.pkt_count !== 7'd1) begin
      n_fail++; $display("FAIL basic_pc1: got %0d want 1", big_if.pkt_count);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({big_if.m_valid, big_if.m_last, big_if.m_data} !== {1'b1, (i == 2), exp[i]}) begin
        n_fail++; $display("FAIL basic_byte%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                           i, big_if.m_valid, big_if.m_last, big_if.m_data, i == 2, exp[i]);
      end
      idle(1);
    end
    n_tests++;
    if (big_if.m_valid !== 1'b0 || big_if.pkt_count !== 7'd0) begin
      n_fail++; $display("FAIL basic_empty: got v=%b pc=%0d want v=0 pc=0", big_if.m_valid, big_if.pkt_count);
    end
  endtask

  task automatic test_two_pkts();
    logic [8:0] exp [3];
    exp = '{9'h1A0, 9'h0B0, 9'h1B1};
    m_ready_big = 1'b0; m_ready_sml = 1'b0;
    send_byte(8'hA0); send_eop();
    send_byte(8'hB0); send_byte(8'hB1); send_eop();
    n_tests++;
    if (big_if.pkt_count !== 7'd2) begin
      n_fail++; $display("FAIL two_pc2: got %0d want 2", big_if.pkt_count);
    end
    m_ready_big = 1'b1; m_ready_sml = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({big_if.m_valid, big_if.m_last, big_if.m_data} !== {1'b1, exp[i]}) begin
        n_fail++; $display("FAIL two_byte%0d: got v=%b %h want v=1 %h",
                           i, big_if.m_valid, {big_if.m_last, big_if.m_data}, exp[i]);
      end
      idle(1);
    end
    n_tests++;
    if (big_if.m_valid !== 1'b0 || big_if.pkt_count !== 7'd0) begin
      n_fail++; $display("FAIL two_empty: got v=%b pc=%0d want v=0 pc=0", big_if.m_valid, big_if.pkt_count);
    end
  endtask

  task automatic test_oversize();
    m_ready_big = 1'b1; m_ready_sml = 1'b1;
    for (int i = 1; i <= BIG_MAXLEN + 1; i++) begin
      send_byte(8'($urandom));
      n_tests++;
      if ({big_if.m_valid, big_if.busy, big_if.drop_pulse} !== {1'b0, 1'b1, (i == BIG_MAXLEN + 1)}) begin
        n_fail++; $display("FAIL over_byte%0d: got v=%b b=%b d=%b want v=0 b=1 d=%b",
                           i, big_if.m_valid, big_if.busy, big_if.drop_pulse, i == BIG_MAXLEN + 1);
      end
    end
    idle(1);
    n_tests++;
    if (big_if.drop_pulse !== 1'b0) begin
      n_fail++; $display("FAIL over_pulse_width: got %b want 0", big_if.drop_pulse);
    end
    send_eop();
    n_tests++;
    if (big_if.busy !== 1'b0 || big_if.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL over_eop: got b=%b v=%b want 0 0", big_if.busy, big_if.m_valid);
    end
    send_byte(8'h5A); send_eop();
    n_tests++;
    if ({big_if.m_valid, big_if.m_last, big_if.m_data, big_if.pkt_count} !== {1'b1, 1'b1, 8'h5A, 7'd1}) begin
      n_fail++; $display("FAIL over_next: got v=%b l=%b d=%h pc=%0d want v=1 l=1 d=5a pc=1",
                         big_if.m_valid, big_if.m_last, big_if.m_data, big_if.pkt_count);
    end
    idle(2);
  endtask

  task automatic test_small_full();
    logic [7:0] p1 [3];
    m_ready_big = 1'b1; m_ready_sml = 1'b0;
    for (int i = 0; i < 3; i++) begin p1[i] = 8'($urandom); send_byte(p1[i]); end
    send_eop();
    n_tests++;
    if (sml_if.pkt_count !== 3'd1) begin
      n_fail++; $display("FAIL full_pc: got %0d want 1", sml_if.pkt_count);
    end
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom));
      n_tests++;
      if ({sml_if.busy, sml_if.drop_pulse} !== {1'b1, (i == 2)}) begin
        n_fail++; $display("FAIL full_byte%0d: got b=%b d=%b want b=1 d=%b",
                           i, sml_if.busy, sml_if.drop_pulse, i == 2);
      end
    end
    send_eop();
    n_tests++;
    if (sml_if.busy !== 1'b0 || sml_if.pkt_count !== 3'd1) begin
      n_fail++; $display("FAIL full_after: got b=%b pc=%0d want b=0 pc=1", sml_if.busy, sml_if.pkt_count);
    end
    m_ready_sml = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({sml_if.m_valid, sml_if.m_last, sml_if.m_data} !== {1'b1, (i == 2), p1[i]}) begin
        n_fail++; $display("FAIL full_read%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                           i, sml_if.m_valid, sml_if.m_last, sml_if.m_data, i == 2, p1[i]);
      end
      idle(1);
    end
    n_tests++;
    if (sml_if.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_empty: got v=%b want 0", sml_if.m_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p [3];
    m_ready_big = 1'b0; m_ready_sml = 1'b0;
    send_byte(8'h77); send_eop();
    send_byte(8'h01); send_byte(8'h02);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({big_if.m_valid, big_if.busy, big_if.pkt_count, sml_if.m_valid, sml_if.busy, sml_if.pkt_count} !== '0) begin
      n_fail++; $display("FAIL rstmid_async: got big v=%b b=%b pc=%0d sml v=%b b=%b pc=%0d want all 0",
                         big_if.m_valid, big_if.busy, big_if.pkt_count,
                         sml_if.m_valid, sml_if.busy, sml_if.pkt_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_ready_big = 1'b1; m_ready_sml = 1'b1;
    for (int i = 0; i < 3; i++) begin p[i] = 8'($urandom); send_byte(p[i]); end
    send_eop();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({big_if.m_valid, big_if.m_last, big_if.m_data} !== {1'b1, (i == 2), p[i]}) begin
        n_fail++; $display("FAIL rstmid_read%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                           i, big_if.m_valid, big_if.m_last, big_if.m_data, i == 2, p[i]);
      end
      idle(1);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 1200; c++) begin
      r = $urandom_range(0, 99);
      m_ready_big = ($urandom_range(0, 3) != 0);
      m_ready_sml = ($urandom_range(0, 2) == 0);
      if (r < 60) begin
        rx_ready = 1'b1; rx_data = 8'($urandom);
      end else if (r < ((c < 600) ? 75 : 62)) begin
        rx_eop = 1'b1;
      end
      @(negedge clk);
      rx_ready = 1'b0; rx_eop = 1'b0;
    end
    m_ready_big = 1'b1; m_ready_sml = 1'b1;
    send_eop();
    idle(80);
    n_tests++;
    if ({big_if.m_valid, big_if.busy, big_if.pkt_count, sml_if.m_valid, sml_if.busy, sml_if.pkt_count} !== '0) begin
      n_fail++; $display("FAIL random_drain: got big v=%b b=%b pc=%0d sml v=%b b=%b pc=%0d want all 0",
                         big_if.m_valid, big_if.busy, big_if.pkt_count,
                         sml_if.m_valid, sml_if.busy, sml_if.pkt_count);
    end
  endtask

`ifdef UART_PKT_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; idle(2); rst_n = 1'b1; idle(1);
    m_ready_big = 1'b1; m_ready_sml = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    send_eop();
    idle(2);
    n_tests++;
    if (sml_if.max_fill !== 3'd3) begin
      n_fail++; $display("FAIL stats_maxfill: got %0d want 3", sml_if.max_fill);
    end
    m_ready_sml = 1'b1;
    idle(4);
    repeat (2) begin
      for (int i = 0; i <= BIG_MAXLEN; i++) send_byte(8'($urandom));
      send_eop();
    end
    n_tests++;
    if (big_if.drop_count !== 16'd2 || sml_if.drop_count !== 16'd2) begin
      n_fail++; $display("FAIL stats_dropcount: got big=%0d sml=%0d want 2 2",
                         big_if.drop_count, sml_if.drop_count);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; rx_ready = 1'b0; rx_eop = 1'b0; rx_data = '0;
    m_ready_big = 1'b0; m_ready_sml = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_two_pkts();
    test_oversize();
    test_small_full();
    test_reset_mid();
    test_random();
`ifdef UART_PKT_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
